// File: rtl/input_conditioner_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : input_conditioner_pkg                              |
// | Description : Shared types and default timing constants for the  |
// |               input conditioner (debounce FSM state encoding).   |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package input_conditioner_pkg;

    // Debounce FSM states; the debounced level is 1 in STABLE_HI and PEND_LO
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } db_state_t;

    localparam int DEF_DEBOUNCE_CYCLES  = 1000000;
    localparam int DEF_SYNC_STAGES      = 2;
    localparam int DEF_LONGPRESS_CYCLES = 200000000;

endpackage : input_conditioner_pkg
`default_nettype wire

// File: rtl/input_conditioner_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : input_conditioner_if                               |
// | Description : Raw button/switch inputs and conditioned outputs.  |
// |               master drives the raw inputs, slave is the block.  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
interface input_conditioner_if;
    logic btn_pause_raw;
    logic sw_sel_raw;
    logic sw_adj_raw;
    logic pause_press;
    logic pause_state;
    logic sel;
    logic adj;
    logic clear_req;

    modport master (
        output btn_pause_raw, sw_sel_raw, sw_adj_raw,
        input  pause_press, pause_state, sel, adj, clear_req
    );

    modport slave (
        input  btn_pause_raw, sw_sel_raw, sw_adj_raw,
        output pause_press, pause_state, sel, adj, clear_req
    );
endinterface : input_conditioner_if
`default_nettype wire

// File: rtl/input_conditioner_debounce_ch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : debounce_ch                                        |
// | Description : One input channel: SYNC_STAGES-deep synchronizer,  |
// |               4-state debounce FSM with qualification counter,   |
// |               registered level, rise pulse and press toggle.     |
// |               INPUT_CONDITIONER_LONGPRESS_EN adds a stable_hi    |
// |               status output used by the long-press timer.        |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module debounce_ch
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
    input  logic MegaClk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic toggle
`ifdef INPUT_CONDITIONER_LONGPRESS_EN
    ,
    output logic stable_hi
`endif
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    db_state_t              state;
    logic [CNT_W-1:0]       cnt;

    // Shift the asynchronous input through the synchronizer chain
    always_ff @(posedge MegaClk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Debounce FSM: a new level is accepted only after DEBOUNCE_CYCLES stable samples
    always_ff @(posedge MegaClk) begin
        if (reset) begin
            state  <= STABLE_LO;
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            toggle <= 1'b0;
        end else begin
            rise <= 1'b0;
            case (state)
                STABLE_LO: begin
                    cnt <= '0;
                    if (synced) state <= PEND_HI;
                end
                PEND_HI: begin
                    if (!synced) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= STABLE_HI;
                        cnt    <= '0;
                        level  <= 1'b1;
                        rise   <= 1'b1;
                        toggle <= ~toggle;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    cnt <= '0;
                    if (!synced) state <= PEND_LO;
                end
                PEND_LO: begin
                    if (synced) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

`ifdef INPUT_CONDITIONER_LONGPRESS_EN
    assign stable_hi = (state == STABLE_HI);
`endif

endmodule : debounce_ch
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : input_conditioner                                  |
// | Description : Debounces the pause button and two slide switches; |
// |               produces a pause press pulse, run/pause toggle and |
// |               debounced switch levels. Optional long-press clear |
// |               request enabled by INPUT_CONDITIONER_LONGPRESS_EN. |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
    parameter int LONGPRESS_CYCLES = DEF_LONGPRESS_CYCLES
) (
    input  logic                 MegaClk,
    input  logic                 reset,
    input_conditioner_if.slave   bus
);

    logic pause_level, pause_rise, pause_toggle;
    logic sel_level,   sel_rise,   sel_toggle;
    logic adj_level,   adj_rise,   adj_toggle;
    logic unused_sink;

`ifdef INPUT_CONDITIONER_LONGPRESS_EN
    logic pause_stable_hi, sel_stable_hi, adj_stable_hi;
`endif

    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_pause (
        .MegaClk   (MegaClk),
        .reset     (reset),
        .raw       (bus.btn_pause_raw),
        .level     (pause_level),
        .rise      (pause_rise),
        .toggle    (pause_toggle)
`ifdef INPUT_CONDITIONER_LONGPRESS_EN
        ,
        .stable_hi (pause_stable_hi)
`endif
    );

    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_sel (
        .MegaClk   (MegaClk),
        .reset     (reset),
        .raw       (bus.sw_sel_raw),
        .level     (sel_level),
        .rise      (sel_rise),
        .toggle    (sel_toggle)
`ifdef INPUT_CONDITIONER_LONGPRESS_EN
        ,
        .stable_hi (sel_stable_hi)
`endif
    );

    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_adj (
        .MegaClk   (MegaClk),
        .reset     (reset),
        .raw       (bus.sw_adj_raw),
        .level     (adj_level),
        .rise      (adj_rise),
        .toggle    (adj_toggle)
`ifdef INPUT_CONDITIONER_LONGPRESS_EN
        ,
        .stable_hi (adj_stable_hi)
`endif
    );

    // The toggle flips on the same edge the rise pulse is raised, so both appear together
    assign bus.pause_press = pause_rise;
    assign bus.pause_state = pause_toggle;
    assign bus.sel         = sel_level;
    assign bus.adj         = adj_level;

`ifdef INPUT_CONDITIONER_LONGPRESS_EN
    localparam int                HOLD_W    = $clog2(LONGPRESS_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONGPRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_DONE = HOLD_W'(LONGPRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              clear_q;

    // Hold timer: counts in STABLE_HI, saturates after firing, re-arms only once the button is released
    always_ff @(posedge MegaClk) begin
        if (reset) begin
            hold_cnt <= '0;
            clear_q  <= 1'b0;
        end else begin
            clear_q <= 1'b0;
            if (!pause_level) begin
                hold_cnt <= '0;
            end else if (pause_stable_hi && (hold_cnt != HOLD_DONE)) begin
                hold_cnt <= hold_cnt + HOLD_ONE;
                if (hold_cnt == HOLD_LAST) clear_q <= 1'b1;
            end
        end
    end

    assign bus.clear_req = clear_q;
    assign unused_sink   = ^{sel_rise, adj_rise, sel_toggle, adj_toggle, sel_stable_hi, adj_stable_hi};
`else
    assign bus.clear_req = 1'b0;
    assign unused_sink   = ^{pause_level, sel_rise, adj_rise, sel_toggle, adj_toggle};
`endif

endmodule : input_conditioner
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_input_conditioner                               |
// | Description : Directed self-checking bench for input_conditioner |
// |               with DEBOUNCE_CYCLES=4, SYNC_STAGES=2,             |
// |               LONGPRESS_CYCLES=20. Cycle k is the interval after |
// |               the k-th rising edge that samples the new input.   |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_input_conditioner;

    logic MegaClk = 1'b0;
    logic reset   = 1'b1;
    int   n_vec   = 0;
    int   n_err   = 0;

    input_conditioner_if bus ();

    input_conditioner #(
        .DEBOUNCE_CYCLES  (4),
        .SYNC_STAGES      (2),
        .LONGPRESS_CYCLES (20)
    ) dut (
        .MegaClk (MegaClk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 MegaClk = ~MegaClk;

    // Compare one observed value against its expected value
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge MegaClk);
        #1;
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b1;
        bus.btn_pause_raw = 1'b0;
        bus.sw_sel_raw    = 1'b0;
        bus.sw_adj_raw    = 1'b0;
        repeat (2) step();
        check_val({tag, ".press"}, 32'(bus.pause_press), 32'd0);
        check_val({tag, ".state"}, 32'(bus.pause_state), 32'd0);
        check_val({tag, ".sel"},   32'(bus.sel),         32'd0);
        check_val({tag, ".adj"},   32'(bus.adj),         32'd0);
        check_val({tag, ".clr"},   32'(bus.clear_req),   32'd0);
        reset = 1'b0;
    endtask

    // Hold the pause button at btn for ncyc cycles; expect a single pulse at pulse_at (-1: none)
    task automatic run_phase(input string tag, input logic btn, input int ncyc,
                             input int pulse_at, input logic st_init);
        logic exp_st;
        bus.btn_pause_raw = btn;
        for (int k = 0; k < ncyc; k++) begin
            step();
            exp_st = (pulse_at >= 0 && k >= pulse_at) ? ~st_init : st_init;
            check_val($sformatf("%s.press[%0d]", tag, k), 32'(bus.pause_press), 32'(k == pulse_at));
            check_val($sformatf("%s.state[%0d]", tag, k), 32'(bus.pause_state), 32'(exp_st));
        end
    endtask

    initial begin
        bit [3:0] bpat;
        int n_press;
        int n_clr;
        int exp_clr;

        bus.btn_pause_raw = 1'b0;
        bus.sw_sel_raw    = 1'b0;
        bus.sw_adj_raw    = 1'b0;

        // Reset state
        apply_reset("rst0");

        // Clean press: pulse and toggle in cycle 6; release gives no pulse
        run_phase("clean",   1'b1, 10,  6, 1'b0);
        run_phase("release", 1'b0, 12, -1, 1'b1);

        // Bounce 1,0,1,0 then held low: nothing changes
        bpat = 4'b0101;
        for (int k = 0; k < 14; k++) begin
            bus.btn_pause_raw = (k < 4) ? bpat[k] : 1'b0;
            step();
            check_val($sformatf("bounce.press[%0d]", k), 32'(bus.pause_press), 32'd0);
            check_val($sformatf("bounce.state[%0d]", k), 32'(bus.pause_state), 32'd1);
        end

        // Double press from reset: state 0 -> 1 -> 0
        apply_reset("rst1");
        run_phase("dbl.p1", 1'b1, 10,  6, 1'b0);
        run_phase("dbl.r1", 1'b0, 10, -1, 1'b1);
        run_phase("dbl.p2", 1'b1, 10,  6, 1'b1);
        run_phase("dbl.r2", 1'b0, 10, -1, 1'b0);

        // Simultaneous sel/adj rise, independent of pause
        apply_reset("rst2");
        bus.sw_sel_raw = 1'b1;
        bus.sw_adj_raw = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check_val($sformatf("simul.sel[%0d]", k),   32'(bus.sel),         32'(k >= 6));
            check_val($sformatf("simul.adj[%0d]", k),   32'(bus.adj),         32'(k >= 6));
            check_val($sformatf("simul.press[%0d]", k), 32'(bus.pause_press), 32'd0);
        end
        // Drop sel only; adj must hold
        bus.sw_sel_raw = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            check_val($sformatf("seldrop.sel[%0d]", k), 32'(bus.sel), 32'(k < 6));
            check_val($sformatf("seldrop.adj[%0d]", k), 32'(bus.adj), 32'd1);
        end

        // Reset in the middle of a pending press discards it; full requalification afterwards
        apply_reset("rst3");
        bus.btn_pause_raw = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check_val($sformatf("midrst.press[%0d]", k), 32'(bus.pause_press), 32'd0);
        end
        reset = 1'b1;
        step();
        check_val("midrst.inrst.press", 32'(bus.pause_press), 32'd0);
        check_val("midrst.inrst.state", 32'(bus.pause_state), 32'd0);
        reset = 1'b0;
        run_phase("midrst.after", 1'b1, 10, 6, 1'b0);

        // Long press: one pause_press; one clear_req only when the feature is built in
        apply_reset("rst4");
        bus.btn_pause_raw = 1'b1;
        n_press = 0;
        n_clr   = 0;
        for (int k = 0; k < 52; k++) begin
            if (k == 40) bus.btn_pause_raw = 1'b0;
            step();
            if (bus.pause_press === 1'b1) n_press++;
            if (bus.clear_req === 1'b1) n_clr++;
        end
`ifdef INPUT_CONDITIONER_LONGPRESS_EN
        exp_clr = 1;
`else
        exp_clr = 0;
`endif
        check_val("long.press_cnt", 32'(n_press), 32'd1);
        check_val("long.clear_cnt", 32'(n_clr), 32'(exp_clr));
        check_val("long.state", 32'(bus.pause_state), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_input_conditioner
`default_nettype wire

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable MegaClk cycles needed to accept a new input level.
REQ-002 Parameter SYNC_STAGES, default 2, flip-flop synchronizer depth per raw input; legal range 2..4.
REQ-003 Parameter LONGPRESS_CYCLES, default 200000000, hold time on debounced pause that raises clear_req; used only when INPUT_CONDITIONER_LONGPRESS_EN is defined.
REQ-004 Port MegaClk  in  1  system clock; all state updates on its rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset, sampled on the rising edge of MegaClk.
REQ-006 Port btn_pause_raw  in  1  asynchronous pause push-button, bouncy.
REQ-007 Port sw_sel_raw  in  1  asynchronous select slide switch.
REQ-008 Port sw_adj_raw  in  1  asynchronous adjust slide switch.
REQ-009 Port pause_press  out  1  one-cycle pulse on each accepted pause press (debounced 0->1).
REQ-010 Port pause_state  out  1  run/pause toggle; 1 = paused; flips on every pause_press.
REQ-011 Port sel  out  1  debounced level of sw_sel_raw.
REQ-012 Port adj  out  1  debounced level of sw_adj_raw.
REQ-013 Port clear_req  out  1  one-cycle long-press pulse; constant 0 when the feature is compiled out.

Function
REQ-014 Each raw input SHALL pass through SYNC_STAGES flip-flops before any use; no raw input reaches logic directly.
REQ-015 Each channel SHALL run a 4-state FSM: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
REQ-016 STABLE_LO->PEND_HI when synced=1; PEND_HI->STABLE_LO when synced=0 (bounce) with counter cleared.
REQ-017 PEND_HI->STABLE_HI when counter reaches DEBOUNCE_CYCLES-1 with synced still 1; PEND_LO/STABLE_HI are symmetric.
REQ-018 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); it increments only in PEND states, clears on any state exit, and never wraps.
REQ-019 Debounced output SHALL equal 1 exactly in STABLE_HI and PEND_LO, so a level held clean changes the output SYNC_STAGES+DEBOUNCE_CYCLES cycles after the raw edge.
REQ-020 pause_press SHALL be high for exactly the one cycle following PEND_HI->STABLE_HI on the pause channel; release produces no pulse.
REQ-021 pause_state SHALL toggle in the same cycle pause_press is high.
REQ-022 sel and adj SHALL be level outputs with no pulse generation; a simultaneous transition on any channel mix SHALL be handled independently per channel.
REQ-023 A bounce shorter than DEBOUNCE_CYCLES SHALL produce no output change and no pulse.

Reset
REQ-024 On reset every FSM SHALL return to STABLE_LO, counters and synchronizer flops clear, and pause_press, pause_state, sel, adj, clear_req SHALL all be 0 the cycle after.
REQ-025 Reset asserted mid-PEND SHALL discard the pending transition; an input still high after reset SHALL requalify with the full latency.

Configuration
REQ-026 Macro INPUT_CONDITIONER_LONGPRESS_EN defined: a hold counter runs while the pause channel is in STABLE_HI, and clear_req pulses once, one cycle, when the count reaches LONGPRESS_CYCLES.
REQ-027 With the macro defined, the pulse SHALL NOT repeat until release and a new press, and a long press SHALL still produce its normal pause_press and toggle.
REQ-028 Macro undefined: no hold counter is synthesized and clear_req is tied 0.

Structure
REQ-029 Package input_conditioner_pkg SHALL hold enum db_state_t (STABLE_LO, PEND_HI, STABLE_HI, PEND_LO) and the default DEBOUNCE_CYCLES/LONGPRESS_CYCLES constants.
REQ-030 Sub-module debounce_ch SHALL contain the synchronizer, FSM and counter for one channel, plus rise-pulse output; it is instantiated 3 times.

Verification (bench params DEBOUNCE_CYCLES=4, SYNC_STAGES=2, LONGPRESS_CYCLES=20)
REQ-031 Clean press: btn_pause_raw 0->1 at cycle 0 and held -> pause_press high only in cycle 6, pause_state 0->1 in cycle 6.
REQ-032 Bounce: btn_pause_raw toggled 1,0,1,0 each cycle then held 0 -> pause_press and pause_state never change.
REQ-033 Double press: two clean presses separated by 10-cycle releases -> two pulses, pause_state 0->1->0.
REQ-034 Simultaneous: sw_sel_raw and sw_adj_raw 0->1 together at cycle 0 -> sel and adj both rise in cycle 6, pause_press stays 0.
REQ-035 Reset mid-PEND: reset at cycle 4 of a press with input held 1 -> outputs 0, pause_press appears 6 cycles after reset deasserts.
REQ-036 Long press (macro defined): pause held 40 cycles -> one pause_press plus exactly one clear_req pulse; macro undefined -> clear_req constant 0.
